// File: rtl/key_scan_pkg.sv
// Shared types and constants for the key matrix scanner: FSM state encoding,
// code-width helper and auto-repeat timing.
package key_scan_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DEBOUNCE,
    ST_HELD,
    ST_REL_DB
  } scan_state_e;

  localparam int REPEAT_FIRST_TICKS = 32;
  localparam int REPEAT_NEXT_TICKS  = 8;

  function automatic int kw_f(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/key_scan_tick.sv
// Free-running divider producing a one-clk scan tick every SCAN_DIV cycles.
module key_scan_tick #(
  parameter int SCAN_DIV = 100
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] LAST = DW'(SCAN_DIV - 1);

  logic [DW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + DW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/key_matrix_scan.sv
// Single-key matrix scanner with press/release debounce and a 1-entry event buffer.
// Optional KEY_REPEAT_EN: auto-repeat press events while a key is held.
module key_matrix_scan
  import key_scan_pkg::*;
#(
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int SCAN_DIV       = 100,
  parameter int DEBOUNCE_TICKS = 16,
  localparam int KW            = kw_f(ROWS * COLS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [ROWS-1:0] row,
  output logic [COLS-1:0] col,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [KW-1:0]   evt_code,
  output logic            evt_press,
  output logic            key_down,
  output logic            ovf
);
  localparam int CW = kw_f(COLS);
  localparam int RW = kw_f(ROWS);
  localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_TICKS);

  scan_state_e     state_q, state_d;
  logic [ROWS-1:0] row_s1_q, row_s2_q;
  logic [COLS-1:0] col_q, col_d;
  logic [CW-1:0]   cidx_q, cidx_d;
  logic [ROWS-1:0] pat_q, pat_d;
  logic [KW-1:0]   code_q, code_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            evt_valid_q, evt_valid_d;
  logic [KW-1:0]   evt_code_q, evt_code_d;
  logic            evt_press_q, evt_press_d;
  logic            key_down_q, key_down_d;
  logic            ovf_q, ovf_d;
  logic            tick, all_high, gen_evt, gen_press;
  logic [RW-1:0]   low_r;
`ifdef KEY_REPEAT_EN
  logic [5:0]      rep_cnt_q, rep_cnt_d;
  logic            rep_first_q, rep_first_d;
`endif

  key_scan_tick #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  assign all_high = &row_s2_q;

  always_comb begin
    low_r = '0;
    for (int i = ROWS - 1; i >= 0; i--)
      if (!row_s2_q[i]) low_r = RW'(i);
  end

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    cidx_d      = cidx_q;
    pat_d       = pat_q;
    code_d      = code_q;
    cnt_d       = cnt_q;
    key_down_d  = key_down_q;
    evt_valid_d = evt_valid_q;
    evt_code_d  = evt_code_q;
    evt_press_d = evt_press_q;
    ovf_d       = ovf_q;
    gen_evt     = 1'b0;
    gen_press   = 1'b0;
`ifdef KEY_REPEAT_EN
    rep_cnt_d   = rep_cnt_q;
    rep_first_d = rep_first_q;
`endif
    case (state_q)
      ST_IDLE: begin
        col_d = '0;
        if (tick && !all_high) begin
          state_d = ST_SCAN;
          cidx_d  = '0;
          col_d   = ~COLS'(1);
        end
      end
      ST_SCAN: if (tick) begin
        if (!all_high) begin
          pat_d   = row_s2_q;
          code_d  = KW'(int'(cidx_q) * ROWS + int'(low_r));
          cnt_d   = '0;
          state_d = ST_DEBOUNCE;
        end else if (cidx_q == CW'(COLS - 1)) begin
          state_d = ST_IDLE;
          col_d   = '0;
        end else begin
          cidx_d = cidx_q + CW'(1);
          col_d  = ~(COLS'(1) << (cidx_q + CW'(1)));
        end
      end
      ST_DEBOUNCE: if (tick) begin
        if (row_s2_q != pat_q) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          col_d   = '0;
        end else if (cnt_q + 8'd1 == DB_LAST) begin
          state_d    = ST_HELD;
          cnt_d      = '0;
          key_down_d = 1'b1;
          gen_evt    = 1'b1;
          gen_press  = 1'b1;
`ifdef KEY_REPEAT_EN
          rep_cnt_d   = '0;
          rep_first_d = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      // Only an all-released row pattern matters here; extra keys are ignored.
      ST_HELD: if (tick) begin
        if (all_high) begin
          state_d = ST_REL_DB;
          cnt_d   = '0;
        end else begin
`ifdef KEY_REPEAT_EN
          rep_cnt_d = rep_cnt_q + 6'd1;
          if (rep_cnt_q + 6'd1 == (rep_first_q ? 6'(REPEAT_FIRST_TICKS)
                                               : 6'(REPEAT_NEXT_TICKS))) begin
            rep_cnt_d   = '0;
            rep_first_d = 1'b0;
            gen_evt     = 1'b1;
            gen_press   = 1'b1;
          end
`endif
        end
      end
      ST_REL_DB: if (tick) begin
        if (!all_high) begin
          state_d = ST_HELD;
          cnt_d   = '0;
        end else if (cnt_q + 8'd1 == DB_LAST) begin
          state_d    = ST_IDLE;
          cnt_d      = '0;
          col_d      = '0;
          key_down_d = 1'b0;
          gen_evt    = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        col_d   = '0;
      end
    endcase

    // A slot frees up in the same cycle it is drained, so no bubble on reload.
    if (gen_evt) begin
      if (!evt_valid_q || evt_ready) begin
        evt_valid_d = 1'b1;
        evt_code_d  = code_q;
        evt_press_d = gen_press;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (evt_valid_q && evt_ready) begin
      evt_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row_s1_q    <= '1;
      row_s2_q    <= '1;
      state_q     <= ST_IDLE;
      col_q       <= '0;
      cidx_q      <= '0;
      pat_q       <= '1;
      code_q      <= '0;
      cnt_q       <= '0;
      key_down_q  <= 1'b0;
      evt_valid_q <= 1'b0;
      evt_code_q  <= '0;
      evt_press_q <= 1'b0;
      ovf_q       <= 1'b0;
`ifdef KEY_REPEAT_EN
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b1;
`endif
    end else begin
      row_s1_q    <= row;
      row_s2_q    <= row_s1_q;
      state_q     <= state_d;
      col_q       <= col_d;
      cidx_q      <= cidx_d;
      pat_q       <= pat_d;
      code_q      <= code_d;
      cnt_q       <= cnt_d;
      key_down_q  <= key_down_d;
      evt_valid_q <= evt_valid_d;
      evt_code_q  <= evt_code_d;
      evt_press_q <= evt_press_d;
      ovf_q       <= ovf_d;
`ifdef KEY_REPEAT_EN
      rep_cnt_q   <= rep_cnt_d;
      rep_first_q <= rep_first_d;
`endif
    end
  end

  assign col       = col_q;
  assign evt_valid = evt_valid_q;
  assign evt_code  = evt_code_q;
  assign evt_press = evt_press_q;
  assign key_down  = key_down_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_key_matrix_scan.sv
// Scoreboard bench for key_matrix_scan: a switch-matrix model drives row from col,
// expected events are queued as {code, press} and popped on each handshake.
module tb_key_matrix_scan;
  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int SD   = 4;
  localparam int DB   = 3;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [ROWS-1:0] row;
  logic [COLS-1:0] col;
  logic            evt_valid, evt_ready, evt_press, key_down, ovf;
  logic [3:0]      evt_code;
  logic [15:0]     keys = '0;

  logic [4:0] sb[$];
  int n_checks = 0;
  int n_pass = 0;
  int evt_seen = 0;

  always #5 clk = ~clk;

  key_matrix_scan #(.ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SD), .DEBOUNCE_TICKS(DB)) dut (
    .clk(clk), .reset(reset), .row(row), .col(col), .evt_valid(evt_valid),
    .evt_ready(evt_ready), .evt_code(evt_code), .evt_press(evt_press),
    .key_down(key_down), .ovf(ovf)
  );

  // A closed switch pulls its row low while its column is driven low.
  always_comb begin
    row = '1;
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++)
        if (keys[c*ROWS+r] && !col[c]) row[r] = 1'b0;
  end

  always @(negedge clk) begin
    if (!reset && evt_valid && evt_ready) begin
      logic [4:0] exp_e;
      evt_seen++;
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_event got code=%0d press=%0d want none", evt_code, evt_press);
      end else begin
        exp_e = sb.pop_front();
        if ({evt_code, evt_press} !== exp_e)
          $display("FAIL event got code=%0d press=%0d want code=%0d press=%0d",
                   evt_code, evt_press, exp_e[4:1], exp_e[0]);
        else n_pass++;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) step(1);
    n_checks++;
    if (sb.size() != 0) $display("FAIL %s pending=%0d want 0", name, sb.size());
    else n_pass++;
  endtask

  task automatic test_reset;
    reset = 1'b1; evt_ready = 1'b1; keys = '0;
    step(3);
    n_checks++; if (col !== 4'b0000) $display("FAIL reset_col got %b want 0000", col); else n_pass++;
    n_checks++; if (evt_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", evt_valid); else n_pass++;
    n_checks++; if (evt_code !== 4'd0) $display("FAIL reset_code got %0d want 0", evt_code); else n_pass++;
    n_checks++; if (evt_press !== 1'b0) $display("FAIL reset_press got %b want 0", evt_press); else n_pass++;
    n_checks++; if (key_down !== 1'b0) $display("FAIL reset_key_down got %b want 0", key_down); else n_pass++;
    n_checks++; if (ovf !== 1'b0) $display("FAIL reset_ovf got %b want 0", ovf); else n_pass++;
    reset = 1'b0;
    step(1);
  endtask

  task automatic test_press_release;
    evt_ready = 1'b1;
    sb.push_back({4'd9, 1'b1});
    keys[9] = 1'b1;
    wait_drain("press9_drain", 50 * SD);
    n_checks++; if (key_down !== 1'b1) $display("FAIL press9_key_down got %b want 1", key_down); else n_pass++;
    n_checks++; if (col !== 4'b1011) $display("FAIL held_col got %b want 1011", col); else n_pass++;
    keys[9] = 1'b0;
    step(2 * SD);
    n_checks++; if (key_down !== 1'b1) $display("FAIL release_early got %b want 1", key_down); else n_pass++;
    sb.push_back({4'd9, 1'b0});
    wait_drain("release9_drain", 50 * SD);
    n_checks++; if (key_down !== 1'b0) $display("FAIL release9_key_down got %b want 0", key_down); else n_pass++;
    step(2 * SD);
    n_checks++; if (col !== 4'b0000) $display("FAIL idle_col got %b want 0000", col); else n_pass++;
    n_checks++; if (evt_valid !== 1'b0) $display("FAIL idle_valid got %b want 0", evt_valid); else n_pass++;
  endtask

  task automatic test_bounce;
    int n0;
    n0 = evt_seen;
    for (int i = 0; i < 10; i++) begin
      keys[6] = ~keys[6];
      step(SD);
    end
    keys[6] = 1'b0;
    step(10 * SD);
    n_checks++; if (evt_seen !== n0) $display("FAIL bounce_events got %0d want %0d", evt_seen, n0); else n_pass++;
    n_checks++; if (key_down !== 1'b0) $display("FAIL bounce_key_down got %b want 0", key_down); else n_pass++;
    n_checks++; if (col !== 4'b0000) $display("FAIL bounce_idle_col got %b want 0000", col); else n_pass++;
  endtask

  task automatic test_overflow;
    evt_ready = 1'b0;
    keys[5] = 1'b1;
    for (int i = 0; i < 50 * SD && !evt_valid; i++) step(1);
    n_checks++; if (evt_valid !== 1'b1) $display("FAIL ovf_press_valid got %b want 1", evt_valid); else n_pass++;
    keys[5] = 1'b0;
    step(20 * SD);
    n_checks++; if (evt_valid !== 1'b1) $display("FAIL ovf_hold_valid got %b want 1", evt_valid); else n_pass++;
    n_checks++; if ({evt_code, evt_press} !== {4'd5, 1'b1})
      $display("FAIL ovf_hold_evt got code=%0d press=%0d want code=5 press=1", evt_code, evt_press);
    else n_pass++;
    n_checks++; if (ovf !== 1'b1) $display("FAIL ovf_flag got %b want 1", ovf); else n_pass++;
    n_checks++; if (key_down !== 1'b0) $display("FAIL ovf_key_down got %b want 0", key_down); else n_pass++;
    sb.push_back({4'd5, 1'b1});
    evt_ready = 1'b1;
    wait_drain("ovf_drain", 10);
    step(2);
    n_checks++; if (evt_valid !== 1'b0) $display("FAIL ovf_after_valid got %b want 0", evt_valid); else n_pass++;
  endtask

  task automatic test_reset_mid_debounce;
    int n0;
    evt_ready = 1'b1;
    keys[15] = 1'b1;
    for (int i = 0; i < 50 * SD && col !== 4'b0111; i++) step(1);
    step(SD + 2);
    n_checks++; if (col !== 4'b0111) $display("FAIL dbnc_col got %b want 0111", col); else n_pass++;
    reset = 1'b1;
    keys = '0;
    step(1);
    n_checks++; if (col !== 4'b0000) $display("FAIL rst_mid_col got %b want 0000", col); else n_pass++;
    n_checks++; if (evt_valid !== 1'b0) $display("FAIL rst_mid_valid got %b want 0", evt_valid); else n_pass++;
    n_checks++; if (key_down !== 1'b0) $display("FAIL rst_mid_key_down got %b want 0", key_down); else n_pass++;
    n_checks++; if (ovf !== 1'b0) $display("FAIL rst_mid_ovf got %b want 0", ovf); else n_pass++;
    reset = 1'b0;
    n0 = evt_seen;
    step(15 * SD);
    n_checks++; if (evt_seen !== n0) $display("FAIL rst_mid_events got %0d want %0d", evt_seen, n0); else n_pass++;
  endtask

  task automatic test_hold_repeat;
    int n0, n_exp;
    n0 = evt_seen;
    n_exp = 2;
    evt_ready = 1'b1;
    sb.push_back({4'd0, 1'b1});
    keys[0] = 1'b1;
    for (int i = 0; i < 50 * SD && !key_down; i++) step(1);
`ifdef KEY_REPEAT_EN
    for (int i = 0; i < 4; i++) sb.push_back({4'd0, 1'b1});
    n_exp = 6;
`endif
    step(10 * SD);
    keys[2] = 1'b1;
    step(10 * SD);
    keys[2] = 1'b0;
    step(38 * SD);
    keys[0] = 1'b0;
    sb.push_back({4'd0, 1'b0});
    wait_drain("hold_drain", 50 * SD);
    n_checks++; if (key_down !== 1'b0) $display("FAIL hold_key_down got %b want 0", key_down); else n_pass++;
    n_checks++; if (evt_seen - n0 !== n_exp)
      $display("FAIL hold_event_count got %0d want %0d", evt_seen - n0, n_exp);
    else n_pass++;
  endtask

  initial begin
    evt_ready = 1'b1;
    test_reset;
    test_press_release;
    test_bounce;
    test_overflow;
    test_reset_mid_debounce;
    test_hold_repeat;
    step(4);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
